// File: rtl/lsu_pkg.sv
// Shared LSU types and sizing used by the store queue and the load queue.
package lsu_pkg;

    localparam int XLEN          = 32;
    localparam int ROB_TAG_WIDTH = 32;
    localparam int STQ_SIZE      = 16;
    localparam int LDQ_SIZE      = 16;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int STQ_IDX_W = idx_width(STQ_SIZE);
    localparam int STQ_CNT_W = $clog2(STQ_SIZE + 1);

    typedef struct packed {
        logic                     valid;
        logic                     address_valid;
        logic                     data_valid;
        logic                     committed;
        logic [XLEN-1:0]          address;
        logic [XLEN-1:0]          data;
        logic [ROB_TAG_WIDTH-1:0] rob_tag;
    } stq_entry_t;

endpackage

// File: rtl/store_queue_if.sv
// Dispatch/AGU/store-data/commit/memory bundle of the store queue, plus its per-entry view.
// STQ_FLUSH_EN adds the flush and flush_rob_tag inputs.
interface store_queue_if;
    import lsu_pkg::*;

    logic                     alloc_stq_entry;
    logic [ROB_TAG_WIDTH-1:0] rob_tag_in;
    logic                     agu_address_valid;
    logic [XLEN-1:0]          agu_address_data;
    logic [ROB_TAG_WIDTH-1:0] agu_address_rob_tag;
    logic                     store_data_valid;
    logic [XLEN-1:0]          store_data;
    logic [ROB_TAG_WIDTH-1:0] store_data_rob_tag;
    logic                     rob_commit;
    logic [ROB_TAG_WIDTH-1:0] rob_commit_tag;
    logic                     mem_ready;
`ifdef STQ_FLUSH_EN
    logic                     flush;
    logic [ROB_TAG_WIDTH-1:0] flush_rob_tag;
`endif

    logic                     mem_write_valid;
    logic [XLEN-1:0]          mem_write_address;
    logic [XLEN-1:0]          mem_write_data;
    logic                     stq_entry_fired;
    logic [STQ_IDX_W-1:0]     stq_entry_fired_index;
    logic [STQ_SIZE-1:0]      store_mask;
    logic [STQ_SIZE-1:0]      stq_valid;
    logic [STQ_SIZE-1:0]      stq_address_valid;
    logic [STQ_SIZE-1:0]      stq_data_valid;
    logic [STQ_SIZE-1:0]      stq_committed;
    logic [XLEN-1:0]          stq_address [STQ_SIZE];
    logic [XLEN-1:0]          stq_data    [STQ_SIZE];
    logic [ROB_TAG_WIDTH-1:0] stq_rob_tag [STQ_SIZE];
    logic [STQ_IDX_W-1:0]     head;
    logic [STQ_IDX_W-1:0]     tail;
    logic                     full;
    logic                     empty;

    modport master (
        output alloc_stq_entry, rob_tag_in, agu_address_valid, agu_address_data,
               agu_address_rob_tag, store_data_valid, store_data, store_data_rob_tag,
               rob_commit, rob_commit_tag, mem_ready,
        input  mem_write_valid, mem_write_address, mem_write_data, stq_entry_fired,
               stq_entry_fired_index, store_mask, stq_valid, stq_address_valid,
               stq_data_valid, stq_committed, stq_address, stq_data, stq_rob_tag,
               head, tail, full, empty
`ifdef STQ_FLUSH_EN
        , output flush, flush_rob_tag
`endif
    );

    modport slave (
        input  alloc_stq_entry, rob_tag_in, agu_address_valid, agu_address_data,
               agu_address_rob_tag, store_data_valid, store_data, store_data_rob_tag,
               rob_commit, rob_commit_tag, mem_ready,
        output mem_write_valid, mem_write_address, mem_write_data, stq_entry_fired,
               stq_entry_fired_index, store_mask, stq_valid, stq_address_valid,
               stq_data_valid, stq_committed, stq_address, stq_data, stq_rob_tag,
               head, tail, full, empty
`ifdef STQ_FLUSH_EN
        , input flush, flush_rob_tag
`endif
    );

endinterface

// File: rtl/stq_entry.sv
// One store-queue slot: allocation, tag-matched address/data capture, commit mark and clear.
module stq_entry
    import lsu_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alloc_en,
    input  logic [ROB_TAG_WIDTH-1:0] alloc_tag,
    input  logic                     agu_valid,
    input  logic [XLEN-1:0]          agu_address,
    input  logic [ROB_TAG_WIDTH-1:0] agu_tag,
    input  logic                     sd_valid,
    input  logic [XLEN-1:0]          sd_data,
    input  logic [ROB_TAG_WIDTH-1:0] sd_tag,
    input  logic                     commit_valid,
    input  logic [ROB_TAG_WIDTH-1:0] commit_tag,
    input  logic                     clear,
    output stq_entry_t               entry
);

    stq_entry_t entry_q;
    stq_entry_t entry_d;

    // Allocation wins over broadcasts, so a capture aimed at a tag being allocated this edge is lost.
    always_comb begin
        entry_d = entry_q;
        if (clear) begin
            entry_d = '0;
        end else if (alloc_en) begin
            entry_d         = '0;
            entry_d.valid   = 1'b1;
            entry_d.rob_tag = alloc_tag;
        end else if (entry_q.valid) begin
            if (agu_valid && (agu_tag == entry_q.rob_tag)) begin
                entry_d.address       = agu_address;
                entry_d.address_valid = 1'b1;
            end
            if (sd_valid && (sd_tag == entry_q.rob_tag)) begin
                entry_d.data       = sd_data;
                entry_d.data_valid = 1'b1;
            end
            if (commit_valid && (commit_tag == entry_q.rob_tag)) begin
                entry_d.committed = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry = entry_q;

endmodule

// File: rtl/store_queue.sv
// In-order store queue: head/tail pointers, occupancy count, in-order drain to memory and store_mask.
// Build with STQ_FLUSH_EN to add the flush that discards all uncommitted entries.
module store_queue
    import lsu_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    store_queue_if.slave  sq
);

    stq_entry_t           entries [STQ_SIZE];
    stq_entry_t           head_entry;
    logic [STQ_IDX_W-1:0] head_q, head_d;
    logic [STQ_IDX_W-1:0] tail_q, tail_d;
    logic [STQ_CNT_W-1:0] count_q, count_d;
    logic [STQ_CNT_W-1:0] committed_cnt;
    logic                 full;
    logic                 empty;
    logic                 alloc_ok;
    logic                 fire;
    logic                 flush_now;
    logic [STQ_SIZE-1:0]  valid_vec;
    logic [STQ_SIZE-1:0]  committed_vec;
    logic [STQ_SIZE-1:0]  fire_vec;
    logic [STQ_SIZE-1:0]  clear_vec;

`ifdef STQ_FLUSH_EN
    logic unused_flush_tag;
    assign flush_now        = sq.flush;
    assign unused_flush_tag = ^sq.flush_rob_tag;
`else
    assign flush_now = 1'b0;
`endif

    assign full       = (count_q == STQ_CNT_W'(STQ_SIZE));
    assign empty      = (count_q == '0);
    assign alloc_ok   = sq.alloc_stq_entry && !full && !flush_now;
    assign head_entry = entries[head_q];
    assign fire       = head_entry.valid && head_entry.committed &&
                        head_entry.address_valid && head_entry.data_valid && sq.mem_ready;

    always_comb begin
        fire_vec         = '0;
        fire_vec[head_q] = fire;
    end

    assign clear_vec = fire_vec | (flush_now ? (valid_vec & ~committed_vec) : '0);

    generate
        for (genvar gi = 0; gi < STQ_SIZE; gi++) begin : g_slot
            stq_entry u_entry (
                .clk          (clk),
                .reset        (reset),
                .alloc_en     (alloc_ok && (tail_q == STQ_IDX_W'(gi))),
                .alloc_tag    (sq.rob_tag_in),
                .agu_valid    (sq.agu_address_valid),
                .agu_address  (sq.agu_address_data),
                .agu_tag      (sq.agu_address_rob_tag),
                .sd_valid     (sq.store_data_valid),
                .sd_data      (sq.store_data),
                .sd_tag       (sq.store_data_rob_tag),
                .commit_valid (sq.rob_commit),
                .commit_tag   (sq.rob_commit_tag),
                .clear        (clear_vec[gi]),
                .entry        (entries[gi])
            );

            assign valid_vec[gi]            = entries[gi].valid;
            assign committed_vec[gi]        = entries[gi].committed;
            assign sq.stq_address_valid[gi] = entries[gi].address_valid;
            assign sq.stq_data_valid[gi]    = entries[gi].data_valid;
            assign sq.stq_address[gi]       = entries[gi].address;
            assign sq.stq_data[gi]          = entries[gi].data;
            assign sq.stq_rob_tag[gi]       = entries[gi].rob_tag;
        end
    endgenerate

    // Commits happen in program order, so committed entries form a contiguous run from head.
    always_comb begin
        committed_cnt = '0;
        for (int i = 0; i < STQ_SIZE; i++) begin
            committed_cnt = committed_cnt + STQ_CNT_W'(committed_vec[i]);
        end
    end

    always_comb begin
        head_d  = head_q + STQ_IDX_W'(fire);
        tail_d  = tail_q + STQ_IDX_W'(alloc_ok);
        count_d = count_q + STQ_CNT_W'(alloc_ok) - STQ_CNT_W'(fire);
        if (flush_now) begin
            tail_d  = head_q + committed_cnt[STQ_IDX_W-1:0];
            count_d = committed_cnt - STQ_CNT_W'(fire);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign sq.mem_write_valid       = head_entry.valid && head_entry.committed &&
                                      head_entry.address_valid && head_entry.data_valid;
    assign sq.mem_write_address     = head_entry.address;
    assign sq.mem_write_data        = head_entry.data;
    assign sq.stq_entry_fired       = fire;
    assign sq.stq_entry_fired_index = head_q;
    assign sq.store_mask            = valid_vec & ~fire_vec;
    assign sq.stq_valid             = valid_vec;
    assign sq.stq_committed         = committed_vec;
    assign sq.head                  = head_q;
    assign sq.tail                  = tail_q;
    assign sq.full                  = full;
    assign sq.empty                 = empty;

endmodule

// File: tb/tb_store_queue.sv
// Self-checking bench for store_queue: direct flag/pointer checks plus a scoreboard of drained stores.
module tb_store_queue;
    import lsu_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    store_queue_if sq ();

    store_queue dut (
        .clk   (clk),
        .reset (reset),
        .sq    (sq)
    );

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   live[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_head = 0;
    int   exp_tail = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp_v);
        end
    endtask

    function automatic logic [31:0] addr_of(input int t);
        return 32'(t) * 32'd16;
    endfunction

    function automatic logic [31:0] data_of(input int t);
        return 32'hA500_0000 ^ 32'(t);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input int tag);
        sq.alloc_stq_entry = 1'b1;
        sq.rob_tag_in      = 32'(tag);
        tick();
        sq.alloc_stq_entry = 1'b0;
    endtask

    task automatic agu(input int tag, input logic [31:0] a);
        sq.agu_address_valid   = 1'b1;
        sq.agu_address_rob_tag = 32'(tag);
        sq.agu_address_data    = a;
        tick();
        sq.agu_address_valid   = 1'b0;
    endtask

    task automatic sdata(input int tag, input logic [31:0] d);
        sq.store_data_valid   = 1'b1;
        sq.store_data_rob_tag = 32'(tag);
        sq.store_data         = d;
        tick();
        sq.store_data_valid   = 1'b0;
    endtask

    task automatic commit(input int tag);
        sq.rob_commit     = 1'b1;
        sq.rob_commit_tag = 32'(tag);
        tick();
        sq.rob_commit     = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.idx  = exp_head;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
        exp_head = (exp_head + 1) % STQ_SIZE;
    endtask

    // Every drained store must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset && sq.stq_entry_fired === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                mon_e = sb.pop_front();
                $display("fire idx=%0d addr=0x%0h data=0x%0h", sq.stq_entry_fired_index,
                         sq.mem_write_address, sq.mem_write_data);
                check("fire_index", 64'(sq.stq_entry_fired_index), 64'(mon_e.idx));
                check("fire_addr", 64'(sq.mem_write_address), 64'(mon_e.addr));
                check("fire_data", 64'(sq.mem_write_data), 64'(mon_e.data));
            end
        end
    end

    initial begin
        logic [STQ_SIZE-1:0] m;
        logic [STQ_SIZE-1:0] one_h;
        int h;
        int t;

        sq.alloc_stq_entry     = 1'b0;
        sq.rob_tag_in          = '0;
        sq.agu_address_valid   = 1'b0;
        sq.agu_address_data    = '0;
        sq.agu_address_rob_tag = '0;
        sq.store_data_valid    = 1'b0;
        sq.store_data          = '0;
        sq.store_data_rob_tag  = '0;
        sq.rob_commit          = 1'b0;
        sq.rob_commit_tag      = '0;
        sq.mem_ready           = 1'b0;
`ifdef STQ_FLUSH_EN
        sq.flush               = 1'b0;
        sq.flush_rob_tag       = '0;
`endif

        // Reset
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_empty", 64'(sq.empty), 64'd1);
        check("rst_full", 64'(sq.full), 64'd0);
        check("rst_store_mask", 64'(sq.store_mask), 64'd0);
        check("rst_mem_write_valid", 64'(sq.mem_write_valid), 64'd0);
        check("rst_head", 64'(sq.head), 64'd0);
        check("rst_tail", 64'(sq.tail), 64'd0);
        check("rst_valid", 64'(sq.stq_valid), 64'd0);

        // Allocation and tag-matched address capture
        alloc(19);
        exp_tail = 1;
        check("alloc_valid", 64'(sq.stq_valid), 64'd1);
        check("alloc_tail", 64'(sq.tail), 64'd1);
        check("alloc_tag", 64'(sq.stq_rob_tag[0]), 64'd19);
        check("alloc_not_empty", 64'(sq.empty), 64'd0);
        agu(7, 32'd42);
        check("agu_wrong_tag", 64'(sq.stq_address_valid[0]), 64'd0);
        agu(19, 32'd42);
        check("agu_match_valid", 64'(sq.stq_address_valid[0]), 64'd1);
        check("agu_match_addr", 64'(sq.stq_address[0]), 64'd42);

        // Data, commit and drain of a single store
        sdata(19, 32'hCAFE);
        check("sd_valid", 64'(sq.stq_data_valid[0]), 64'd1);
        check("mwv_uncommitted", 64'(sq.mem_write_valid), 64'd0);
        push_exp(32'd42, 32'hCAFE);
        commit(19);
        check("mwv_ready", 64'(sq.mem_write_valid), 64'd1);
        check("mw_addr", 64'(sq.mem_write_address), 64'd42);
        check("mw_data", 64'(sq.mem_write_data), 64'hCAFE);
        sq.mem_ready = 1'b1;
        #1;
        check("fired", 64'(sq.stq_entry_fired), 64'd1);
        check("fired_index", 64'(sq.stq_entry_fired_index), 64'd0);
        check("mask_on_fire", 64'(sq.store_mask), 64'd0);
        tick();
        sq.mem_ready = 1'b0;
        check("post_fire_valid", 64'(sq.stq_valid), 64'd0);
        check("post_fire_head", 64'(sq.head), 64'd1);
        check("post_fire_empty", 64'(sq.empty), 64'd1);

        // Fill to full, overflow alloc, fire with alloc in the same cycle
        for (int i = 0; i < STQ_SIZE; i++) begin
            alloc(100 + i);
            live.push_back(100 + i);
            exp_tail = (exp_tail + 1) % STQ_SIZE;
        end
        check("fill_full", 64'(sq.full), 64'd1);
        check("fill_tail", 64'(sq.tail), 64'(exp_tail));
        alloc(200);
        check("overflow_full", 64'(sq.full), 64'd1);
        check("overflow_tail", 64'(sq.tail), 64'(exp_tail));
        check("overflow_tag", 64'(sq.stq_rob_tag[exp_tail]), 64'd100);

        t = live.pop_front();
        agu(t, addr_of(t));
        sdata(t, data_of(t));
        push_exp(addr_of(t), data_of(t));
        commit(t);
        sq.mem_ready       = 1'b1;
        sq.alloc_stq_entry = 1'b1;
        sq.rob_tag_in      = 32'd201;
        tick();
        sq.alloc_stq_entry = 1'b0;
        sq.mem_ready       = 1'b0;
        check("full_fire_count", 64'($countones(sq.stq_valid)), 64'd15);
        check("full_fire_not_full", 64'(sq.full), 64'd0);
        check("full_fire_tail", 64'(sq.tail), 64'(exp_tail));
        check("full_fire_head", 64'(sq.head), 64'(exp_head));

        t = live.pop_front();
        agu(t, addr_of(t));
        sdata(t, data_of(t));
        push_exp(addr_of(t), data_of(t));
        commit(t);
        sq.mem_ready       = 1'b1;
        sq.alloc_stq_entry = 1'b1;
        sq.rob_tag_in      = 32'd202;
        tick();
        sq.alloc_stq_entry = 1'b0;
        sq.mem_ready       = 1'b0;
        check("fire_alloc_count", 64'($countones(sq.stq_valid)), 64'd15);
        check("fire_alloc_tag", 64'(sq.stq_rob_tag[exp_tail]), 64'd202);
        exp_tail = (exp_tail + 1) % STQ_SIZE;
        live.push_back(202);
        check("fire_alloc_tail", 64'(sq.tail), 64'(exp_tail));
        check("fire_alloc_head", 64'(sq.head), 64'(exp_head));

        // Drain everything still in flight, wrapping the pointers
        sq.mem_ready = 1'b1;
        while (live.size() > 0) begin
            t = live.pop_front();
            agu(t, addr_of(t));
            sdata(t, data_of(t));
            push_exp(addr_of(t), data_of(t));
            commit(t);
        end
        for (int i = 0; i < 20 && sq.empty !== 1'b1; i++) begin
            tick();
        end
        sq.mem_ready = 1'b0;
        check("drain_empty", 64'(sq.empty), 64'd1);
        check("drain_head", 64'(sq.head), 64'(exp_head));
        check("drain_tail", 64'(sq.tail), 64'(exp_tail));
        check("drain_sb_left", 64'(sb.size()), 64'd0);

        // store_mask with one committed store waiting on address/data
        h = exp_head;
        m = '0;
        for (int k = 0; k < 3; k++) begin
            alloc(300 + k);
            m[(h + k) % STQ_SIZE] = 1'b1;
            exp_tail = (exp_tail + 1) % STQ_SIZE;
        end
        live.push_back(301);
        live.push_back(302);
        commit(300);
        check("mask_three", 64'(sq.store_mask), 64'(m));
        check("mask_mwv_no_addr", 64'(sq.mem_write_valid), 64'd0);
        agu(300, addr_of(300));
        check("mask_mwv_no_data", 64'(sq.mem_write_valid), 64'd0);
        sdata(300, data_of(300));
        check("mask_mwv_ready", 64'(sq.mem_write_valid), 64'd1);
        check("mask_not_ready", 64'(sq.store_mask), 64'(m));
        push_exp(addr_of(300), data_of(300));
        sq.mem_ready = 1'b1;
        #1;
        one_h = STQ_SIZE'(1) << h;
        check("mask_fire_drop", 64'(sq.store_mask), 64'(m & ~one_h));
        tick();
        sq.mem_ready = 1'b0;
        check("mask_after_head", 64'(sq.head), 64'(exp_head));

`ifdef STQ_FLUSH_EN
        // Flush keeps only the committed head entry
        alloc(303);
        alloc(304);
        exp_tail = (exp_tail + 2) % STQ_SIZE;
        commit(301);
        sq.flush = 1'b1;
        tick();
        sq.flush = 1'b0;
        one_h = STQ_SIZE'(1) << exp_head;
        check("flush_valid", 64'(sq.stq_valid), 64'(one_h));
        check("flush_tail", 64'(sq.tail), 64'((exp_head + 1) % STQ_SIZE));
        check("flush_count", 64'($countones(sq.stq_valid)), 64'd1);
        check("flush_not_empty", 64'(sq.empty), 64'd0);
`endif

        repeat (2) tick();
        check("final_sb_left", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
